// File: rtl/mmu_pkg.sv
// Shared types for the systolic-array output path.
package mmu_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int DEPTH     = 4;

    typedef logic [BIT_WIDTH-1:0] pix_t;
    typedef pix_t [DEPTH-1:0]     row_t;

endpackage

// File: rtl/mmu_row_fifo.sv
// Synchronous row FIFO; pointers carry one extra wrap bit to tell full from empty.
module mmu_row_fifo
    import mmu_pkg::*;
#(
    parameter type data_t     = row_t,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  data_t push_data,
    output logic  full,
    output logic  empty,
    output data_t head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    data_t       mem [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmu_output_deskew.sv
// Re-aligns the column-skewed bottom-row PE results into whole rows and
// buffers them for the downstream writeback over valid/ready.
module mmu_output_deskew #(
    parameter int BIT_WIDTH  = mmu_pkg::BIT_WIDTH,
    parameter int DEPTH      = mmu_pkg::DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [BIT_WIDTH*DEPTH-1:0] col_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_WIDTH*DEPTH-1:0] out_data,
    output logic [15:0]                row_count,
    output logic                       overflow
);

    localparam int ROW_W = BIT_WIDTH * DEPTH;

    logic [DEPTH-2:0] vld_dly;
    logic [ROW_W-1:0] aligned_row;
    logic             aligned;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_dly <= '0;
        end else begin
            vld_dly[0] <= in_valid;
            for (int i = 1; i < DEPTH - 1; i++) begin
                vld_dly[i] <= vld_dly[i-1];
            end
        end
    end

    assign aligned = vld_dly[DEPTH-2];

    // Column c arrives c cycles late, so it waits DEPTH-1-c cycles to meet the last column.
    for (genvar c = 0; c < DEPTH; c++) begin : g_col
        localparam int NREG = DEPTH - 1 - c;
        if (NREG == 0) begin : g_direct
            assign aligned_row[BIT_WIDTH*c +: BIT_WIDTH] = col_data[BIT_WIDTH*c +: BIT_WIDTH];
        end else begin : g_dly
            logic [BIT_WIDTH-1:0] stage [NREG];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < NREG; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= col_data[BIT_WIDTH*c +: BIT_WIDTH];
                    for (int i = 1; i < NREG; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end
            assign aligned_row[BIT_WIDTH*c +: BIT_WIDTH] = stage[NREG-1];
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    mmu_row_fifo #(
        .data_t     (logic [ROW_W-1:0]),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (aligned),
        .pop       (pop),
        .push_data (aligned_row),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            row_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop) begin
                row_count <= row_count + 16'd1;
            end
            if (aligned && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmu_output_deskew.sv
// Scoreboard bench for mmu_output_deskew: skewed row feed, queue of expected rows.
module tb_mmu_output_deskew;

    localparam int BW = 16;
    localparam int DP = 4;
    localparam int FD = 4;
    localparam int RW = BW * DP;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] col_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [15:0]   row_count;
    logic          overflow;

    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [RW-1:0] sb_q[$];
    logic [RW-1:0] feed_q[$];
    bit            keep_q[$];
    int            pop_cyc_q[$];
    logic          vld_before_last;

    mmu_output_deskew #(
        .BIT_WIDTH  (BW),
        .DEPTH      (DP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .col_data  (col_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .row_count (row_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Observe half a cycle away from the edge; a pop happens at the following posedge.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_row", {63'd0, out_valid}, 64'd0);
            end else if (out_ready) begin
                check("pop_data", out_data, sb_q.pop_front());
                pop_cyc_q.push_back(cyc);
            end else begin
                check("stall_hold", out_data, sb_q[0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic add_row(logic [RW-1:0] w, bit k);
        feed_q.push_back(w);
        keep_q.push_back(k);
    endtask

    // Drive the queued rows with the diagonal skew: column c of row r at cycle r+c.
    task automatic feed(int ready_at);
        int            n;
        int            r;
        logic [RW-1:0] w;
        n = feed_q.size();
        for (int t = 0; t < n + DP - 1; t++) begin
            in_valid = (t < n);
            for (int c = 0; c < DP; c++) begin
                r = t - c;
                if (r >= 0 && r < n) begin
                    w = feed_q[r];
                    col_data[BW*c +: BW] = w[BW*c +: BW];
                end else begin
                    col_data[BW*c +: BW] = BW'($urandom);
                end
            end
            if (t < n && keep_q[t]) sb_q.push_back(feed_q[t]);
            if (t == ready_at) out_ready = 1'b1;
            if (t == n + DP - 2) vld_before_last = out_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        feed_q.delete();
        keep_q.delete();
    endtask

    task automatic drain(string tag);
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check(tag, 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        col_data  = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_row_count", {48'd0, row_count}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);

        // single row, latency E+3
        out_ready = 1'b1;
        add_row(64'h0044_0033_0022_0011, 1'b1);
        feed(-1);
        check("single_not_early", {63'd0, vld_before_last}, 64'd0);
        check("single_valid", {63'd0, out_valid}, 64'd1);
        check("single_data", out_data, 64'h0044_0033_0022_0011);
        @(posedge clk); #1;
        check("single_pulse", {63'd0, out_valid}, 64'd0);
        check("single_count", {48'd0, row_count}, 64'd1);

        // back-to-back rows
        pop_cyc_q.delete();
        for (int r = 0; r < 4; r++) begin
            add_row({16'(12 + r), 16'(8 + r), 16'(4 + r), 16'(r)}, 1'b1);
        end
        feed(-1);
        drain("b2b_drain");
        check("b2b_pops", 64'(pop_cyc_q.size()), 64'd4);
        if (pop_cyc_q.size() == 4) check("b2b_no_bubble", 64'(pop_cyc_q[3] - pop_cyc_q[0]), 64'd3);
        check("b2b_count", {48'd0, row_count}, 64'd5);

        // backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 5; r++) add_row({$urandom, $urandom}, r < 4);
        feed(-1);
        @(posedge clk); #1;
        check("ovf_set", {63'd0, overflow}, 64'd1);
        check("ovf_valid_held", {63'd0, out_valid}, 64'd1);
        check("ovf_count_before", {48'd0, row_count}, 64'd0);
        out_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_count_after", {48'd0, row_count}, 64'd4);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        check("ovf_empty", {63'd0, out_valid}, 64'd0);

        // full FIFO, pop and push on the same edge
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) add_row({$urandom, $urandom}, 1'b1);
        feed(-1);
        add_row({$urandom, $urandom}, 1'b1);
        feed(DP - 1);
        check("simul_no_ovf", {63'd0, overflow}, 64'd0);
        drain("simul_drain");
        check("simul_count", {48'd0, row_count}, 64'd5);

        // reset in the middle of a row
        out_ready = 1'b1;
        in_valid  = 1'b1;
        col_data  = {$urandom, $urandom};
        @(posedge clk); #1;
        in_valid = 1'b0;
        col_data = {$urandom, $urandom};
        rst      = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_data", out_data, 64'd0);
        check("midrst_count", {48'd0, row_count}, 64'd0);
        check("midrst_overflow", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            col_data = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        check("midrst_no_row", {63'd0, out_valid}, 64'd0);
        add_row(64'h1234_5678_9abc_def0, 1'b1);
        feed(-1);
        drain("midrst_fresh_drain");
        check("midrst_fresh_count", {48'd0, row_count}, 64'd1);

        // row_count wrap after 65536 pops
        do_reset();
        out_ready = 1'b1;
        pop_cyc_q.delete();
        for (int r = 0; r < 65536; r++) add_row({$urandom, $urandom}, 1'b1);
        feed(-1);
        drain("wrap_drain");
        check("wrap_pops", 64'(pop_cyc_q.size()), 64'd65536);
        check("wrap_count", {48'd0, row_count}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
